uart_rx_baudsel: RTL and testbench

// - UART receiver; downstream peer of the baud-selectable transmitter. Recovers 8N1 frames from a serial line.
// - Start bit validated at mid-bit; data sampled at mid-bit, LSB first; stop bit checked for framing.
// - Emits a one-cycle data-valid strobe with the byte, or a framing-error strobe.
// - Sits between the pad/loopback serial input and the byte-consumer logic.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_baudsel.sv | 141 ++++++++++++++
 tb/tb_uart_rx_baudsel.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, baud constants
// and the baud_select to clocks-per-bit mapping.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_CLEANUP = 3'd4
   } uart_state_e;

   localparam int unsigned CLKS_PER_BIT_9600  = 1042;
   localparam int unsigned CLKS_PER_BIT_19200 = 521;
   localparam int unsigned CLKS_PER_BIT_38400 = 261;
   localparam int unsigned CLKS_PER_BIT_57600 = 174;

   localparam int unsigned CNT_W = 11;

   function automatic logic [CNT_W-1:0] clks_per_bit(input logic [1:0] baud_select);
      logic [CNT_W-1:0] c;
      case (baud_select)
         2'b00:   c = CNT_W'(CLKS_PER_BIT_9600);
         2'b01:   c = CNT_W'(CLKS_PER_BIT_19200);
         2'b10:   c = CNT_W'(CLKS_PER_BIT_38400);
         default: c = CNT_W'(CLKS_PER_BIT_57600);
      endcase
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so no false start bit is seen coming out of reset.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Sync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= i_Async;
         sync_q <= meta_q;
      end
   end

   assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx_baudsel.sv
// 8N1 UART receiver with per-frame baud selection; start bit validated and data
// sampled at mid-bit, stop bit checked for framing.
module uart_rx_baudsel
   import uart_pkg::*;
(
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   input  logic [1:0] baud_select,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   logic             rx_s;
   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cpb_q, cpb_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             dv_q, dv_d;
   logic             fe_q, fe_d;
   logic             active_q, active_d;
   logic [CNT_W-1:0] half_m1;
   logic [CNT_W-1:0] full_m1;

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Async (i_Rx_Serial),
      .o_Sync  (rx_s)
   );

   // Bit period is frozen for the whole frame once the start edge is seen.
   assign half_m1 = {1'b0, cpb_q[CNT_W-1:1]} - CNT_W'(1);
   assign full_m1 = cpb_q - CNT_W'(1);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= ST_IDLE;
         cpb_q     <= '0;
         count_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cpb_q     <= cpb_d;
         count_q   <= count_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
         active_q  <= active_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (!rx_s) state_d = ST_START;
         ST_START:   if (count_q == half_m1) state_d = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:    if (count_q == full_m1 && bit_idx_q == 3'd7) state_d = ST_STOP;
         ST_STOP:    if (count_q == full_m1) state_d = ST_CLEANUP;
         ST_CLEANUP: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cpb_d     = cpb_q;
      count_d   = count_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
      active_d  = active_q;
      case (state_q)
         ST_IDLE: begin
            count_d   = '0;
            bit_idx_d = '0;
            if (!rx_s) begin
               active_d = 1'b1;
               cpb_d    = clks_per_bit(baud_select);
            end
         end
         ST_START: begin
            if (count_q == half_m1) begin
               count_d = '0;
               if (rx_s) active_d = 1'b0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (count_q == full_m1) begin
               count_d            = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = (bit_idx_q == 3'd7) ? 3'd0 : bit_idx_q + 3'd1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (count_q == full_m1) begin
               count_d = '0;
               if (rx_s) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_CLEANUP: begin
            count_d  = '0;
            active_d = 1'b0;
         end
         default: begin
            count_d   = '0;
            bit_idx_d = '0;
            active_d  = 1'b0;
         end
      endcase
   end

   assign o_Rx_DV        = dv_q;
   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Frame_Err = fe_q;
   assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_baudsel.sv
// Directed bench for uart_rx_baudsel: a serial line driver feeds frames and a
// negedge monitor checks each strobe against the expected-result queues.
module tb_uart_rx_baudsel;

   logic       i_Clock = 1'b0;
   logic       i_Rst_n = 1'b0;
   logic       i_Rx_Serial = 1'b1;
   logic [1:0] baud_select = 2'b11;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Rx_Frame_Err;
   logic       o_Rx_Active;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int active_cnt = 0;
   logic [7:0] model_byte = 8'h00;

   logic [7:0] exp_q[$];
   int         exp_cyc_q[$];
   int         fe_cyc_q[$];
   logic [7:0] fe_hold_q[$];

   uart_rx_baudsel dut (
      .i_Clock        (i_Clock),
      .i_Rst_n        (i_Rst_n),
      .i_Rx_Serial    (i_Rx_Serial),
      .baud_select    (baud_select),
      .o_Rx_DV        (o_Rx_DV),
      .o_Rx_Byte      (o_Rx_Byte),
      .o_Rx_Frame_Err (o_Rx_Frame_Err),
      .o_Rx_Active    (o_Rx_Active)
   );

   // clock / cycle counter
   always #5 i_Clock = ~i_Clock;
   always @(posedge i_Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int clks(input logic [1:0] bs);
      case (bs)
         2'b00:   return 1042;
         2'b01:   return 521;
         2'b10:   return 261;
         default: return 174;
      endcase
   endfunction

   task automatic drive_bit(input logic v, input int c);
      i_Rx_Serial = v;
      repeat (c) @(negedge i_Clock);
   endtask

   // Called at a negedge; returns at the negedge ending the stop bit with the
   // line already back high. baud_select is scrambled after the start bit.
   task automatic send_frame(input logic [7:0] b, input logic [1:0] bs, input logic stop_bit);
      int c;
      int t0;
      c = clks(bs);
      baud_select = bs;
      t0 = cyc + 1;
      if (stop_bit) begin
         exp_q.push_back(b);
         exp_cyc_q.push_back(t0 + 2 + c / 2 + 9 * c);
         model_byte = b;
      end else begin
         fe_cyc_q.push_back(t0 + 2 + c / 2 + 9 * c);
         fe_hold_q.push_back(model_byte);
      end
      drive_bit(1'b0, c);
      baud_select = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) drive_bit(b[i], c);
      drive_bit(stop_bit, c);
      i_Rx_Serial = 1'b1;
   endtask

   // scoreboard monitor
   always @(negedge i_Clock) begin
      if (o_Rx_Active) active_cnt++;
      if (o_Rx_DV && o_Rx_Frame_Err) check("dv_fe_overlap", 32'd1, 32'd0);
      if (o_Rx_DV) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dv", 32'd1, 32'd0);
         end else begin
            check("dv_byte", 32'(o_Rx_Byte), 32'(exp_q.pop_front()));
            check("dv_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
         end
      end
      if (o_Rx_Frame_Err) begin
         if (fe_cyc_q.size() == 0) begin
            check("unexpected_fe", 32'd1, 32'd0);
         end else begin
            check("fe_cycle", 32'(cyc), 32'(fe_cyc_q.pop_front()));
            check("fe_byte_hold", 32'(o_Rx_Byte), 32'(fe_hold_q.pop_front()));
         end
      end
   end

   initial begin
      logic [7:0] pat [3];
      pat[0] = 8'h00;
      pat[1] = 8'hFF;
      pat[2] = 8'h3C;

      // reset
      repeat (3) @(negedge i_Clock);
      check("rst_dv", 32'(o_Rx_DV), 32'd0);
      check("rst_byte", 32'(o_Rx_Byte), 32'd0);
      check("rst_fe", 32'(o_Rx_Frame_Err), 32'd0);
      check("rst_active", 32'(o_Rx_Active), 32'd0);
      i_Rst_n = 1'b1;
      repeat (5) @(negedge i_Clock);

      // first frame at the fastest rate
      send_frame(8'hA5, 2'b11, 1'b1);
      repeat (10) @(negedge i_Clock);

      // every baud rate with the corner patterns
      for (int bs = 0; bs < 4; bs++) begin
         for (int p = 0; p < 3; p++) begin
            send_frame(pat[p], 2'(bs), 1'b1);
            repeat (10) @(negedge i_Clock);
         end
      end

      // short low glitch on an idle line
      baud_select = 2'b11;
      repeat (10) @(negedge i_Clock);
      active_cnt = 0;
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 200);
      check("glitch_active_cycles", 32'(active_cnt), 32'd87);
      check("glitch_active_low", 32'(o_Rx_Active), 32'd0);

      // framing error keeps the previous byte
      send_frame(8'h5A, 2'b11, 1'b0);
      repeat (300) @(negedge i_Clock);
      check("fe_active_low", 32'(o_Rx_Active), 32'd0);

      // back-to-back frames with no idle gap
      send_frame(8'h12, 2'b11, 1'b1);
      send_frame(8'h34, 2'b11, 1'b1);
      repeat (10) @(negedge i_Clock);

      // reset in the middle of data bit 4
      baud_select = 2'b11;
      drive_bit(1'b0, 174);
      for (int i = 0; i < 4; i++) drive_bit(1'(i & 1), 174);
      drive_bit(1'b1, 87);
      i_Rst_n = 1'b0;
      repeat (2) @(negedge i_Clock);
      check("midrst_dv", 32'(o_Rx_DV), 32'd0);
      check("midrst_byte", 32'(o_Rx_Byte), 32'd0);
      check("midrst_fe", 32'(o_Rx_Frame_Err), 32'd0);
      check("midrst_active", 32'(o_Rx_Active), 32'd0);
      i_Rx_Serial = 1'b1;
      repeat (5) @(negedge i_Clock);
      i_Rst_n = 1'b1;
      model_byte = 8'h00;
      repeat (2000) @(negedge i_Clock);
      check("postrst_byte", 32'(o_Rx_Byte), 32'd0);
      check("postrst_active", 32'(o_Rx_Active), 32'd0);
      send_frame(8'h77, 2'b11, 1'b1);
      repeat (20) @(negedge i_Clock);
      check("final_byte", 32'(o_Rx_Byte), 32'h77);

      // every expected strobe must have been seen
      check("dv_queue_drained", 32'(exp_q.size()), 32'd0);
      check("fe_queue_drained", 32'(fe_cyc_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
